// File: rtl/decode_if.sv
// decode_if: fetch/writeback inputs and execute-side decode packet of the decode stage.
interface decode_if;
    logic [31:0] insn_in;
    logic [31:0] pc_in;
    logic        insn_valid;
    logic        stall_in;
    logic        wb_enable;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] insn_out;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    modport master (
        output insn_in, pc_in, insn_valid, stall_in, wb_enable, wb_addr, wb_data,
        input  stall, valid_out, pc_out, insn_out, opcode, rs, rt, rd, shamt, funct,
               imm_sext, rs_data, rt_data
    );
    modport slave (
        input  insn_in, pc_in, insn_valid, stall_in, wb_enable, wb_addr, wb_data,
        output stall, valid_out, pc_out, insn_out, opcode, rs, rt, rd, shamt, funct,
               imm_sext, rs_data, rt_data
    );
endinterface

// File: rtl/decode.sv
// decode: MIPS decode stage with register file, write-through bypass,
// load-use hazard detection and a one-entry replay buffer.
module decode #(
    parameter logic [31:0] RESET_PC = 32'h80020000
) (
    input logic     clock,
    input logic     reset,
    decode_if.slave bus
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    logic [0:0]  state;
    logic [31:0] regs [32];
    logic [31:0] buf_insn, buf_pc, src_insn, src_pc, src_rs_data, src_rt_data;
    logic [4:0]  src_rs, src_rt;
    logic        buf_valid, src_valid, is_load, hazard;
    assign buf_valid = state == HOLD;
    assign src_insn  = buf_valid ? buf_insn : bus.insn_in;
    assign src_pc    = buf_valid ? buf_pc : bus.pc_in;
    assign src_valid = buf_valid | bus.insn_valid;
    assign src_rs    = src_insn[25:21];
    assign src_rt    = src_insn[20:16];
    // Reads see a same-cycle writeback; index 0 is hardwired to zero.
    assign src_rs_data = src_rs == 5'd0 ? 32'd0 :
                         (bus.wb_enable && bus.wb_addr == src_rs) ? bus.wb_data : regs[src_rs];
    assign src_rt_data = src_rt == 5'd0 ? 32'd0 :
                         (bus.wb_enable && bus.wb_addr == src_rt) ? bus.wb_data : regs[src_rt];
    assign is_load = bus.opcode inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    assign hazard  = bus.valid_out && is_load && bus.rt != 5'd0 &&
                     (bus.rt == src_rs || bus.rt == src_rt);
    assign bus.stall = hazard | bus.stall_in | buf_valid;
    assign bus.opcode   = bus.insn_out[31:26];
    assign bus.rs       = bus.insn_out[25:21];
    assign bus.rt       = bus.insn_out[20:16];
    assign bus.rd       = bus.insn_out[15:11];
    assign bus.shamt    = bus.insn_out[10:6];
    assign bus.funct    = bus.insn_out[5:0];
    assign bus.imm_sext = {{16{bus.insn_out[15]}}, bus.insn_out[15:0]};
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (bus.wb_enable && bus.wb_addr != 5'd0) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            buf_insn <= '0;
            buf_pc   <= '0;
        end else if (state == RUN && bus.insn_valid && (hazard || bus.stall_in)) begin
            state    <= HOLD;
            buf_insn <= bus.insn_in;
            buf_pc   <= bus.pc_in;
        end else if (state == HOLD && !hazard && !bus.stall_in) begin
            state <= RUN;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.valid_out <= 1'b0;
            bus.pc_out    <= RESET_PC;
            bus.insn_out  <= '0;
            bus.rs_data   <= '0;
            bus.rt_data   <= '0;
        end else if (!bus.stall_in) begin
            if (hazard) begin
                bus.valid_out <= 1'b0;
                bus.insn_out  <= '0;
                bus.rs_data   <= '0;
                bus.rt_data   <= '0;
            end else if (src_valid) begin
                bus.valid_out <= 1'b1;
                bus.pc_out    <= src_pc;
                bus.insn_out  <= src_insn;
                bus.rs_data   <= src_rs_data;
                bus.rt_data   <= src_rt_data;
            end else begin
                bus.valid_out <= 1'b0;
            end
        end
    end
endmodule
